// File: rtl/modmul_reduce_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_pkg
//  Description : Shared constants for the Q=8380417 modular multiply path:
//                modulus, operand/product widths and the initiator FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_pkg;

    localparam int         Q_WIDTH    = 23;
    localparam int         MUL_WIDTH  = 2 * Q_WIDTH;   // full a*b width (46)
    localparam int         PROD_WIDTH = 48;            // reducer data_in width
    localparam logic [22:0] Q         = 23'd8380417;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage : mod_pkg
`default_nettype wire

// File: rtl/modmul_reduce_initiator_shiftadd.sv
`default_nettype none
// ============================================================================
//  Module      : modmul_shiftadd
//  Description : Bit-serial 23x23 shift-add multiplier. One multiplier bit per
//                cycle, LSB first; 23 busy cycles per product, no DSP blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module modmul_shiftadd
    import mod_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [Q_WIDTH-1:0]   a,
    input  logic [Q_WIDTH-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [MUL_WIDTH-1:0] prod
);

    localparam logic [4:0] LAST_BIT = 5'(Q_WIDTH - 1);

    logic [Q_WIDTH-1:0]   a_q, a_d;
    logic [Q_WIDTH-1:0]   b_q, b_d;
    logic [MUL_WIDTH-1:0] acc_q, acc_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic                 busy_q, busy_d;

    // Next-state: latch operands on start, then add one shifted partial product per cycle
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        if (start) begin
            a_d       = a;
            b_d       = b;
            acc_d     = '0;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            if (b_q[bit_cnt_q]) begin
                acc_d = acc_q + (MUL_WIDTH'(a_q) << bit_cnt_q);
            end
            if (bit_cnt_q == LAST_BIT) begin
                busy_d = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // done marks the final bit cycle; prod is complete on the following cycle
    assign busy = busy_q;
    assign done = busy_q && (bit_cnt_q == LAST_BIT);
    assign prod = acc_q;

endmodule : modmul_shiftadd
`default_nettype wire

// File: rtl/modmul_reduce_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : modmul_reduce_initiator
//  Description : Accepts (a,b), forms a*b bit-serially, drives the Barrett
//                reducer as initiator and returns a*b mod Q on a valid/ready
//                port. One operation in flight; sticky reducer timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module modmul_reduce_initiator
    import mod_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Q_WIDTH-1:0]    in_a,
    input  logic [Q_WIDTH-1:0]    in_b,
    output logic                  red_start,
    output logic [PROD_WIDTH-1:0] red_data,
    input  logic                  red_done,
    input  logic [Q_WIDTH-1:0]    red_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    out_data,
    output logic                  timeout_err
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [WC_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [Q_WIDTH-1:0]   out_data_q, out_data_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [MUL_WIDTH-1:0] mul_prod;

    modmul_shiftadd u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (in_a),
        .b     (in_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // FSM next-state, wait timer, result capture and sticky timeout flag
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;
        mul_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The multiplier is always idle here; the gate only guards
                // against ever restarting a pass that is still running.
                if (in_valid && !mul_busy) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion arriving on the last timer cycle still wins
                if (red_done) begin
                    out_data_d = red_result;
                    state_d    = ST_OUT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            out_data_q    <= out_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    // red_data tracks the multiplier accumulator, which is stable from ISSUE
    // until the next operation is accepted.
    assign in_ready    = (state_q == ST_IDLE);
    assign red_start   = (state_q == ST_ISSUE);
    assign out_valid   = (state_q == ST_OUT);
    assign red_data    = {{(PROD_WIDTH - MUL_WIDTH){1'b0}}, mul_prod};
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;

endmodule : modmul_reduce_initiator
`default_nettype wire

// File: tb/tb_modmul_reduce_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modmul_reduce_initiator
//  Description : Self-checking bench for modmul_reduce_initiator with a
//                behavioural reducer responder and an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modmul_reduce_initiator;

    localparam longint unsigned MODQ = 64'd8380417;
    localparam int              TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] in_a = '0;
    logic [22:0] in_b = '0;
    logic        red_start;
    logic [47:0] red_data;
    logic        red_done = 1'b0;
    logic [22:0] red_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [22:0] out_data;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // responder controls and observations
    int          resp_delay = 3;
    bit          resp_stub  = 1'b0;
    int          resp_cnt   = -1;
    logic [47:0] resp_held  = '0;
    int          start_count = 0;
    int          start_cyc   = 0;
    logic [47:0] last_red_data = '0;

    modmul_reduce_initiator #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .red_start   (red_start),
        .red_data    (red_data),
        .red_done    (red_done),
        .red_result  (red_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reducer responder: done pulse resp_delay cycles after the start cycle
    always @(negedge clk) begin
        red_done = 1'b0;
        if (rst) begin
            resp_cnt = -1;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    red_done   = 1'b1;
                    red_result = 23'(64'(resp_held) % MODQ);
                    resp_cnt   = -1;
                end
            end
            if (red_start) begin
                resp_held     = red_data;
                last_red_data = red_data;
                start_count   = start_count + 1;
                start_cyc     = cyc;
                resp_cnt      = resp_stub ? -1 : resp_delay;
            end
        end
    end

    function automatic longint unsigned model_prod(input logic [22:0] a, input logic [22:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Issue one operation and wait (bounded) for out_valid; no handshake
    task automatic do_op(input logic [22:0] a, input logic [22:0] b,
                         output logic [22:0] got, output logic [47:0] rd,
                         output int nstart, output int lat_s, output int lat_o,
                         output bit seen);
        int acc_cyc;
        int s0;
        in_a = a; in_b = b; in_valid = 1'b1;
        acc_cyc = cyc;
        s0 = start_count;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 23'($urandom); in_b = 23'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        got    = out_data;
        rd     = last_red_data;
        nstart = start_count - s0;
        lat_s  = start_cyc - acc_cyc;
        lat_o  = cyc - start_cyc;
    endtask

    task automatic accept_out(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (red_start !== 1'b0) begin n_err++; $display("FAIL reset_red_start got=%b exp=0", red_start); end
        n_vec++; if (red_data !== 48'd0) begin n_err++; $display("FAIL reset_red_data got=%0d exp=0", red_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_data !== 23'd0) begin n_err++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_directed();
        logic [22:0] ta [3] = '{23'd1, 23'd8380416, 23'd4194304};
        logic [22:0] tb [3] = '{23'd1, 23'd8380416, 23'd2};
        logic [47:0] erd[3] = '{48'd1, 48'd70231372333056, 48'd8388608};
        logic [22:0] eo [3] = '{23'd1, 23'd1, 23'd8191};
        logic [22:0] got; logic [47:0] rd; int ns, ls, lo; bit seen;
        for (int i = 0; i < 3; i++) begin
            resp_delay = 2 + i;
            do_op(ta[i], tb[i], got, rd, ns, ls, lo, seen);
            n_vec++; if (!seen) begin n_err++; $display("FAIL dir%0d_out_valid_timeout got=0 exp=1", i); end
            n_vec++; if (got !== eo[i]) begin n_err++; $display("FAIL dir%0d_out_data got=%0d exp=%0d", i, got, eo[i]); end
            n_vec++; if (rd !== erd[i]) begin n_err++; $display("FAIL dir%0d_red_data got=%0d exp=%0d", i, rd, erd[i]); end
            n_vec++; if (ns != 1) begin n_err++; $display("FAIL dir%0d_start_count got=%0d exp=1", i, ns); end
            n_vec++; if (ls != 24) begin n_err++; $display("FAIL dir%0d_start_latency got=%0d exp=24", i, ls); end
            n_vec++; if (lo != resp_delay + 1) begin n_err++; $display("FAIL dir%0d_out_latency got=%0d exp=%0d", i, lo, resp_delay + 1); end
            accept_out(0);
        end
    endtask

    task automatic test_backpressure();
        logic [22:0] got; logic [47:0] rd; int ns, ls, lo; bit seen;
        resp_delay = 4;
        do_op(23'd3, 23'd4194305, got, rd, ns, ls, lo, seen);
        n_vec++; if (got !== 23'd4202498) begin n_err++; $display("FAIL bp_out_data got=%0d exp=4202498", got); end
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
            n_vec++; if (out_data !== 23'd4202498) begin n_err++; $display("FAIL bp_hold_data[%0d] got=%0d exp=4202498", i, out_data); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
        end
        accept_out(0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    endtask

    // Completion in the last timer cycle must still be captured
    task automatic test_done_at_timeout();
        logic [22:0] a, b, got; logic [47:0] rd; int ns, ls, lo; bit seen;
        a = 23'($urandom); b = 23'($urandom);
        resp_delay = TMO;
        do_op(a, b, got, rd, ns, ls, lo, seen);
        n_vec++; if (got !== 23'(model_prod(a, b) % MODQ)) begin n_err++; $display("FAIL edge_out_data got=%0d exp=%0d", got, 23'(model_prod(a, b) % MODQ)); end
        n_vec++; if (lo != TMO + 1) begin n_err++; $display("FAIL edge_out_latency got=%0d exp=%0d", lo, TMO + 1); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL edge_timeout_err got=%b exp=0", timeout_err); end
        accept_out(1);
    endtask

    task automatic test_random();
        logic [22:0] a, b, got; logic [47:0] rd; int ns, ls, lo; bit seen;
        longint unsigned p;
        for (int i = 0; i < 20; i++) begin
            a = 23'($urandom); b = 23'($urandom);
            if (i == 0) b = 23'h7FFFFF;
            if (i == 1) a = 23'd0;
            resp_delay = int'($urandom_range(1, 10));
            p = model_prod(a, b);
            do_op(a, b, got, rd, ns, ls, lo, seen);
            n_vec++; if (got !== 23'(p % MODQ) || !seen) begin n_err++; $display("FAIL rnd%0d_out_data a=%0d b=%0d got=%0d exp=%0d", i, a, b, got, 23'(p % MODQ)); end
            n_vec++; if (rd !== 48'(p)) begin n_err++; $display("FAIL rnd%0d_red_data got=%0d exp=%0d", i, rd, p); end
            n_vec++; if (ns != 1 || ls != 24 || lo != resp_delay + 1) begin n_err++; $display("FAIL rnd%0d_timing got starts=%0d lat_s=%0d lat_o=%0d exp 1/24/%0d", i, ns, ls, lo, resp_delay + 1); end
            accept_out(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_timeout();
        logic [22:0] got; logic [47:0] rd; int ns, ls, lo; bit seen, saw_ov;
        int te_lat;
        resp_stub = 1'b1;
        in_a = 23'd12345; in_b = 23'd678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0; saw_ov = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) saw_ov = 1'b1;
            if (timeout_err) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        te_lat = cyc - start_cyc;
        n_vec++; if (!seen) begin n_err++; $display("FAIL tmo_flag got=0 exp=1"); end
        n_vec++; if (te_lat != TMO + 1) begin n_err++; $display("FAIL tmo_latency got=%0d exp=%0d", te_lat, TMO + 1); end
        n_vec++; if (saw_ov) begin n_err++; $display("FAIL tmo_out_valid got=1 exp=0"); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tmo_in_ready got=%b exp=1", in_ready); end
        resp_stub = 1'b0;
        resp_delay = 3;
        do_op(23'd1000, 23'd9000, got, rd, ns, ls, lo, seen);
        n_vec++; if (got !== 23'(model_prod(23'd1000, 23'd9000) % MODQ)) begin n_err++; $display("FAIL tmo_next_out_data got=%0d exp=%0d", got, 23'(model_prod(23'd1000, 23'd9000) % MODQ)); end
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
        accept_out(0);
    endtask

    task automatic test_reset_mid();
        logic [22:0] got; logic [47:0] rd; int ns, ls, lo; bit seen;
        in_a = 23'h7FFFFF; in_b = 23'h7FFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_busy_in_ready got=%b exp=0", in_ready); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (red_start !== 1'b0) begin n_err++; $display("FAIL rmid_red_start got=%b exp=0", red_start); end
        n_vec++; if (red_data !== 48'd0) begin n_err++; $display("FAIL rmid_red_data got=%0d exp=0", red_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_data !== 23'd0) begin n_err++; $display("FAIL rmid_out_data got=%0d exp=0", out_data); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rmid_timeout_err got=%b exp=0", timeout_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        resp_delay = 2;
        do_op(23'd5, 23'd7, got, rd, ns, ls, lo, seen);
        n_vec++; if (got !== 23'd35 || !seen) begin n_err++; $display("FAIL rmid_after_out_data got=%0d exp=35", got); end
        n_vec++; if (ns != 1 || rd !== 48'd35) begin n_err++; $display("FAIL rmid_after_red got starts=%0d data=%0d exp 1/35", ns, rd); end
        accept_out(0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_done_at_timeout();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_modmul_reduce_initiator
`default_nettype wire
